// File: rtl/rf_writeback_queue.sv
// In-order writeback queue feeding the register file write port, with optional
// forwarding lookups (enabled by defining RF_WB_FORWARD_EN).
module rf_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  input  logic [ADDR_W-1:0]          look_addr1,
  input  logic [ADDR_W-1:0]          look_addr2,
  output logic                       look_hit1,
  output logic                       look_hit2,
  output logic [DATA_W-1:0]          look_data1,
  output logic [DATA_W-1:0]          look_data2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic              push;
  logic              pop;

  assign in_ready = (count < CW'(DEPTH));
  // x0 results complete the handshake but are dropped here
  assign push     = in_valid && in_ready && (in_addr != '0);
  assign pop      = (count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head    <= head + 1'b1;
        wr_addr <= addr_q[head];
        wr_data <= data_q[head];
      end
      wr_en <= pop;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage has no reset; occupancy is tracked solely by head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= in_addr;
      data_q[tail] <= in_data;
    end
  end

`ifdef RF_WB_FORWARD_EN
  always_comb begin
    logic [PW-1:0] idx;
    look_hit1  = 1'b0;
    look_hit2  = 1'b0;
    look_data1 = '0;
    look_data2 = '0;
    idx        = '0;
    // Oldest first (output stage, then head..tail) so the youngest match wins.
    if (wr_en && (wr_addr == look_addr1) && (look_addr1 != '0)) begin
      look_hit1  = 1'b1;
      look_data1 = wr_data;
    end
    if (wr_en && (wr_addr == look_addr2) && (look_addr2 != '0)) begin
      look_hit2  = 1'b1;
      look_data2 = wr_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        if ((addr_q[idx] == look_addr1) && (look_addr1 != '0)) begin
          look_hit1  = 1'b1;
          look_data1 = data_q[idx];
        end
        if ((addr_q[idx] == look_addr2) && (look_addr2 != '0)) begin
          look_hit2  = 1'b1;
          look_data2 = data_q[idx];
        end
      end
    end
  end
`else
  logic unused_look;
  assign unused_look = ^{look_addr1, look_addr2};
  assign look_hit1   = 1'b0;
  assign look_hit2   = 1'b0;
  assign look_data1  = '0;
  assign look_data2  = '0;
`endif

endmodule
